// File: rtl/alu_scheduler_if.sv
// Request, ALU and response signals of alu_scheduler grouped as one bundle.
// master = requesters, consumer and ALU side; slave = the scheduler.
interface alu_scheduler_if;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_instr;
    logic [31:0] a_op1;
    logic [31:0] a_op2;

    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_instr;
    logic [31:0] b_op1;
    logic [31:0] b_op2;

    logic [4:0]  alu_instruction;
    logic [31:0] alu_num1;
    logic [31:0] alu_num2;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;

    modport master (
        output a_valid, a_instr, a_op1, a_op2,
        input  a_ready,
        output b_valid, b_instr, b_op1, b_op2,
        input  b_ready,
        input  alu_instruction, alu_num1, alu_num2,
        output alu_result, alu_flags,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  a_valid, a_instr, a_op1, a_op2,
        output a_ready,
        input  b_valid, b_instr, b_op1, b_op2,
        output b_ready,
        output alu_instruction, alu_num1, alu_num2,
        input  alu_result, alu_flags,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_scheduler.sv
// Round-robin two-requester sequencer for the shared ALU; ALU_SCHED_PERF_CNT_EN adds perf counters.
// Latency: accept to rsp_valid = ALU_LATENCY+1 cycles (1 cycle for an illegal opcode).
// Backpressure: one op outstanding; no request is accepted until the response handshake completes.
module alu_scheduler #(
    parameter int ALU_LATENCY = 1,
    parameter int OPC_MAX     = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_scheduler_if.slave       bus
`ifdef ALU_SCHED_PERF_CNT_EN
    ,
    output logic [15:0]          perf_a_ops,
    output logic [15:0]          perf_b_ops,
    output logic [15:0]          perf_busy
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [5:0] OPC_LIMIT = 6'(OPC_MAX);
    localparam logic [2:0] LAT_LOAD  = 3'(ALU_LATENCY);

    state_t      state;
    logic        rr_ptr;
    logic [2:0]  cnt;

    logic        gnt_a;
    logic        gnt_b;
    logic [4:0]  sel_instr;
    logic [31:0] sel_op1;
    logic [31:0] sel_op2;
    logic        sel_legal;

    // Ready is forced low while reset is held so every output reads 0 in reset.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (rst_n && state == IDLE) begin
            if (bus.a_valid && bus.b_valid) begin
                gnt_a = ~rr_ptr;
                gnt_b = rr_ptr;
            end else begin
                gnt_a = bus.a_valid;
                gnt_b = bus.b_valid;
            end
        end
    end

    assign bus.a_ready = gnt_a;
    assign bus.b_ready = gnt_b;

    assign sel_instr = gnt_b ? bus.b_instr : bus.a_instr;
    assign sel_op1   = gnt_b ? bus.b_op1   : bus.a_op1;
    assign sel_op2   = gnt_b ? bus.b_op2   : bus.a_op2;
    assign sel_legal = (sel_instr != 5'd0) && ({1'b0, sel_instr} <= OPC_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            rr_ptr              <= 1'b0;
            cnt                 <= 3'd0;
            bus.alu_instruction <= 5'd0;
            bus.alu_num1        <= 32'd0;
            bus.alu_num2        <= 32'd0;
            bus.rsp_valid       <= 1'b0;
            bus.rsp_id          <= 1'b0;
            bus.rsp_result      <= 32'd0;
            bus.rsp_flags       <= 4'd0;
            bus.rsp_err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_a || gnt_b) begin
                        bus.rsp_id <= gnt_b;
                        if (sel_legal) begin
                            bus.alu_instruction <= sel_instr;
                            bus.alu_num1        <= sel_op1;
                            bus.alu_num2        <= sel_op2;
                            cnt                 <= LAT_LOAD;
                            state               <= EXEC;
                        end else begin
                            // Illegal opcodes never reach the ALU.
                            bus.rsp_err    <= 1'b1;
                            bus.rsp_result <= 32'd0;
                            bus.rsp_flags  <= 4'd0;
                            bus.rsp_valid  <= 1'b1;
                            state          <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        bus.rsp_result      <= bus.alu_result;
                        bus.rsp_flags       <= bus.alu_flags;
                        bus.rsp_err         <= 1'b0;
                        bus.rsp_valid       <= 1'b1;
                        bus.alu_instruction <= 5'd0;
                        state               <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        rr_ptr        <= ~bus.rsp_id;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SCHED_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_a_ops <= 16'd0;
            perf_b_ops <= 16'd0;
            perf_busy  <= 16'd0;
        end else begin
            if (state != IDLE && perf_busy != 16'hFFFF) begin
                perf_busy <= perf_busy + 16'd1;
            end
            if (state == RESP && bus.rsp_ready) begin
                if (bus.rsp_id) begin
                    if (perf_b_ops != 16'hFFFF) perf_b_ops <= perf_b_ops + 16'd1;
                end else begin
                    if (perf_a_ops != 16'hFFFF) perf_a_ops <= perf_a_ops + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: one instance at ALU_LATENCY=1, one at ALU_LATENCY=3,
// each in front of a small registered ALU model.
module tb_alu_scheduler;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_scheduler_if bus1();
    alu_scheduler_if bus3();

    alu_scheduler #(.ALU_LATENCY(1), .OPC_MAX(18)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    alu_scheduler #(.ALU_LATENCY(3), .OPC_MAX(18)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // ALU model: {flags{V,C,Z,N}, result}; NOP/unknown opcodes keep the flag register.
    function automatic logic [35:0] alu_f(input logic [4:0] op, input logic [31:0] x,
                                          input logic [31:0] y, input logic [3:0] fl);
        logic [32:0] s;
        logic [31:0] r;
        logic [3:0]  f;
        f = fl;
        r = 32'd0;
        s = 33'd0;
        case (op)
            5'd1: begin r = x & y; f = {2'b00, r == 32'd0, r[31]}; end
            5'd4: begin r = x ^ y; f = {2'b00, r == 32'd0, r[31]}; end
            5'd6: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[31:0];
                f = {(x[31] == y[31]) && (r[31] != x[31]), s[32], r == 32'd0, r[31]};
            end
            5'd8: begin
                s = {1'b0, x} - {1'b0, y};
                r = s[31:0];
                f = {(x[31] != y[31]) && (r[31] != x[31]), ~s[32], r == 32'd0, r[31]};
            end
            default: r = 32'd0;
        endcase
        return {f, r};
    endfunction

    logic [35:0] p1 = '0;
    logic [35:0] q0 = '0, q1 = '0, q2 = '0;

    always @(posedge clk) p1 <= alu_f(bus1.alu_instruction, bus1.alu_num1, bus1.alu_num2, p1[35:32]);
    always @(posedge clk) begin
        q0 <= alu_f(bus3.alu_instruction, bus3.alu_num1, bus3.alu_num2, q0[35:32]);
        q1 <= q0;
        q2 <= q1;
    end

    assign bus1.alu_result = p1[31:0];
    assign bus1.alu_flags  = p1[35:32];
    assign bus3.alu_result = q2[31:0];
    assign bus3.alu_flags  = q2[35:32];

    logic [38:0] rsp1, rsp3;
    logic [68:0] alu1, alu3;
    assign rsp1 = {bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result, bus1.rsp_flags, bus1.rsp_err};
    assign rsp3 = {bus3.rsp_valid, bus3.rsp_id, bus3.rsp_result, bus3.rsp_flags, bus3.rsp_err};
    assign alu1 = {bus1.alu_instruction, bus1.alu_num1, bus1.alu_num2};
    assign alu3 = {bus3.alu_instruction, bus3.alu_num1, bus3.alu_num2};

    task automatic test_reset();
        rst_n = 1'b0;
        bus1.a_valid = 1'b1; bus1.a_instr = 5'd1; bus1.a_op1 = 32'hF0; bus1.a_op2 = 32'h0F;
        bus1.b_valid = 1'b1; bus1.b_instr = 5'd4; bus1.b_op1 = 32'hFF; bus1.b_op2 = 32'h0F;
        bus1.rsp_ready = 1'b1;
        bus3.a_valid = 1'b0; bus3.a_instr = 5'd0; bus3.a_op1 = 32'd0; bus3.a_op2 = 32'd0;
        bus3.b_valid = 1'b0; bus3.b_instr = 5'd0; bus3.b_op1 = 32'd0; bus3.b_op2 = 32'd0;
        bus3.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus1.a_ready, bus1.b_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b want 00", {bus1.a_ready, bus1.b_ready});
        end
        checks++;
        if (alu1 !== '0) begin errors++; $display("FAIL reset_alu got %h want 0", alu1); end
        checks++;
        if (rsp1 !== '0) begin errors++; $display("FAIL reset_rsp got %h want 0", rsp1); end
        checks++;
        if ({alu3, rsp3} !== '0) begin errors++; $display("FAIL reset_lat3 got %h want 0", {alu3, rsp3}); end
        rst_n = 1'b1;
    endtask

    task automatic test_contention();
        int n;
        #1;
        checks++;
        if ({bus1.a_ready, bus1.b_ready} !== 2'b10) begin
            errors++; $display("FAIL cont_grant_a got %b want 10", {bus1.a_ready, bus1.b_ready});
        end
        @(negedge clk);
        bus1.a_valid = 1'b0;
        checks++;
        if (bus1.alu_instruction !== 5'd1) begin
            errors++; $display("FAIL cont_instr got %0d want 1", bus1.alu_instruction);
        end
        n = 0;
        while (!bus1.rsp_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (rsp1 !== {1'b1, 1'b0, 32'h0, 4'b0010, 1'b0}) begin
            errors++; $display("FAIL cont_rsp_a got %h want %h", rsp1, {1'b1, 1'b0, 32'h0, 4'b0010, 1'b0});
        end
        bus1.a_valid = 1'b1; bus1.a_instr = 5'd4; bus1.a_op1 = 32'd3; bus1.a_op2 = 32'd5;
        #1;
        checks++;
        if ({bus1.a_ready, bus1.b_ready} !== 2'b00) begin
            errors++; $display("FAIL cont_resp_ready got %b want 00", {bus1.a_ready, bus1.b_ready});
        end
        @(negedge clk);
        checks++;
        if ({bus1.a_ready, bus1.b_ready} !== 2'b01) begin
            errors++; $display("FAIL cont_grant_b got %b want 01", {bus1.a_ready, bus1.b_ready});
        end
        @(negedge clk);
        bus1.b_valid = 1'b0;
        n = 0;
        while (!bus1.rsp_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (rsp1 !== {1'b1, 1'b1, 32'hF0, 4'b0000, 1'b0}) begin
            errors++; $display("FAIL cont_rsp_b got %h want %h", rsp1, {1'b1, 1'b1, 32'hF0, 4'b0000, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({bus1.a_ready, bus1.b_ready, bus1.rsp_valid} !== 3'b100) begin
            errors++; $display("FAIL cont_third_grant got %b want 100", {bus1.a_ready, bus1.b_ready, bus1.rsp_valid});
        end
        @(negedge clk);
        bus1.a_valid = 1'b0;
        n = 0;
        while (!bus1.rsp_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (rsp1 !== {1'b1, 1'b0, 32'd6, 4'b0000, 1'b0}) begin
            errors++; $display("FAIL cont_rsp_third got %h want %h", rsp1, {1'b1, 1'b0, 32'd6, 4'b0000, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        int n, hi, ar;
        bus1.a_valid = 1'b1; bus1.a_instr = 5'd6; bus1.a_op1 = 32'd5; bus1.a_op2 = 32'd7;
        #1;
        n = 0; ar = 0;
        while (!bus1.a_ready && n < 20) begin @(negedge clk); n++; end
        if (bus1.a_ready) ar++;
        @(negedge clk);
        bus1.a_valid = 1'b0;
        n = 0; hi = 0;
        while (!bus1.rsp_valid && n < 20) begin
            if (bus1.alu_instruction == 5'd6) hi++;
            if (bus1.a_ready) ar++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 2) begin errors++; $display("FAIL single_latency got %0d want 2", n); end
        checks++;
        if (hi !== 2) begin errors++; $display("FAIL single_instr_hold got %0d want 2", hi); end
        checks++;
        if (ar !== 1) begin errors++; $display("FAIL single_ready_pulses got %0d want 1", ar); end
        checks++;
        if (rsp1 !== {1'b1, 1'b0, 32'd12, 4'b0000, 1'b0}) begin
            errors++; $display("FAIL single_rsp got %h want %h", rsp1, {1'b1, 1'b0, 32'd12, 4'b0000, 1'b0});
        end
        @(negedge clk);
        checks++;
        if (bus1.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_clear got %b want 0", bus1.rsp_valid); end
    endtask

    task automatic test_illegal();
        int n;
        bus1.b_valid = 1'b1; bus1.b_instr = 5'h1F; bus1.b_op1 = 32'd1; bus1.b_op2 = 32'd2;
        #1;
        n = 0;
        while (!bus1.b_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        bus1.b_valid = 1'b0;
        checks++;
        if (bus1.alu_instruction !== 5'd0) begin
            errors++; $display("FAIL illegal_alu got %0d want 0", bus1.alu_instruction);
        end
        checks++;
        if (rsp1 !== {1'b1, 1'b1, 32'd0, 4'b0000, 1'b1}) begin
            errors++; $display("FAIL illegal_rsp got %h want %h", rsp1, {1'b1, 1'b1, 32'd0, 4'b0000, 1'b1});
        end
        @(negedge clk);
        checks++;
        if ({bus1.rsp_valid, bus1.alu_instruction} !== 6'd0) begin
            errors++; $display("FAIL illegal_after got %h want 0", {bus1.rsp_valid, bus1.alu_instruction});
        end
    endtask

    task automatic test_opc_bounds();
        logic [4:0] opc [0:2];
        logic       exp_err [0:2];
        int         exp_lat [0:2];
        logic [4:0] first;
        int         n;
        opc = '{5'd0, 5'd18, 5'd19};
        exp_err = '{1'b1, 1'b0, 1'b1};
        exp_lat = '{0, 2, 0};
        for (int i = 0; i < 3; i++) begin
            bus1.a_valid = 1'b1; bus1.a_instr = opc[i]; bus1.a_op1 = 32'd1; bus1.a_op2 = 32'd1;
            #1;
            n = 0;
            while (!bus1.a_ready && n < 20) begin @(negedge clk); n++; end
            @(negedge clk);
            bus1.a_valid = 1'b0;
            first = bus1.alu_instruction;
            n = 0;
            while (!bus1.rsp_valid && n < 20) begin @(negedge clk); n++; end
            checks++;
            if (bus1.rsp_err !== exp_err[i]) begin
                errors++; $display("FAIL opc_err[%0d] got %b want %b", opc[i], bus1.rsp_err, exp_err[i]);
            end
            checks++;
            if (n !== exp_lat[i]) begin
                errors++; $display("FAIL opc_latency[%0d] got %0d want %0d", opc[i], n, exp_lat[i]);
            end
            checks++;
            if (first !== (exp_err[i] ? 5'd0 : opc[i])) begin
                errors++; $display("FAIL opc_alu[%0d] got %0d want %0d", opc[i], first, exp_err[i] ? 5'd0 : opc[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int n, bad;
        bus1.rsp_ready = 1'b0;
        bus1.a_valid = 1'b1; bus1.a_instr = 5'd8; bus1.a_op1 = 32'd9; bus1.a_op2 = 32'd4;
        #1;
        n = 0;
        while (!bus1.a_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        bus1.a_valid = 1'b0;
        bus1.b_valid = 1'b1; bus1.b_instr = 5'd1; bus1.b_op1 = 32'd3; bus1.b_op2 = 32'd1;
        n = 0;
        while (!bus1.rsp_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (rsp1 !== {1'b1, 1'b0, 32'd5, 4'b0100, 1'b0}) begin
            errors++; $display("FAIL bp_rsp got %h want %h", rsp1, {1'b1, 1'b0, 32'd5, 4'b0100, 1'b0});
        end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp1 !== {1'b1, 1'b0, 32'd5, 4'b0100, 1'b0} || bus1.a_ready || bus1.b_ready) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
        bus1.rsp_ready = 1'b1;
        #1;
        checks++;
        if ({bus1.rsp_valid, bus1.b_ready} !== 2'b10) begin
            errors++; $display("FAIL bp_pre_hs got %b want 10", {bus1.rsp_valid, bus1.b_ready});
        end
        @(negedge clk);
        checks++;
        if ({bus1.rsp_valid, bus1.b_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_hs got %b want 01", {bus1.rsp_valid, bus1.b_ready});
        end
        @(negedge clk);
        bus1.b_valid = 1'b0;
        n = 0;
        while (!bus1.rsp_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (rsp1 !== {1'b1, 1'b1, 32'd1, 4'b0000, 1'b0}) begin
            errors++; $display("FAIL bp_rsp_b got %h want %h", rsp1, {1'b1, 1'b1, 32'd1, 4'b0000, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int n, bad;
        bus1.a_valid = 1'b1; bus1.a_instr = 5'd8; bus1.a_op1 = 32'd9; bus1.a_op2 = 32'd4;
        #1;
        n = 0;
        while (!bus1.a_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        bus1.a_valid = 1'b0;
        checks++;
        if (bus1.alu_instruction !== 5'd8) begin
            errors++; $display("FAIL rst_exec got %0d want 8", bus1.alu_instruction);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({alu1, rsp1, bus1.a_ready, bus1.b_ready} !== '0) begin
            errors++; $display("FAIL rst_async got %h want 0", {alu1, rsp1});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus1.rsp_valid || bus1.alu_instruction != 5'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rst_no_rsp got %0d bad cycles want 0", bad); end
        bus1.a_valid = 1'b1;
        #1;
        n = 0;
        while (!bus1.a_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        bus1.a_valid = 1'b0;
        n = 0;
        while (!bus1.rsp_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if ({n[3:0], rsp1} !== {4'd2, 1'b1, 1'b0, 32'd5, 4'b0100, 1'b0}) begin
            errors++; $display("FAIL rst_next_op got %0d/%h want 2/%h", n, rsp1, {1'b1, 1'b0, 32'd5, 4'b0100, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int t [0:2];
        int k;
        int n;
        t = '{0, 0, 0};
        k = 0;
        bus1.a_valid = 1'b1; bus1.a_instr = 5'd6; bus1.a_op1 = 32'd1; bus1.a_op2 = 32'd1;
        #1;
        for (int c = 0; c < 40 && k < 3; c++) begin
            if (bus1.a_ready) begin t[k] = c; k++; end
            @(negedge clk);
        end
        bus1.a_valid = 1'b0;
        checks++;
        if (k !== 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", k); end
        checks++;
        if (t[1] - t[0] !== 4 || t[2] - t[1] !== 4) begin
            errors++; $display("FAIL b2b_spacing got %0d,%0d want 4,4", t[1] - t[0], t[2] - t[1]);
        end
        n = 0;
        while (!bus1.rsp_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (rsp1 !== {1'b1, 1'b0, 32'd2, 4'b0000, 1'b0}) begin
            errors++; $display("FAIL b2b_rsp got %h want %h", rsp1, {1'b1, 1'b0, 32'd2, 4'b0000, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_latency3();
        int n, hi;
        bus3.a_valid = 1'b1; bus3.a_instr = 5'd8; bus3.a_op1 = 32'd3; bus3.a_op2 = 32'd3;
        #1;
        n = 0;
        while (!bus3.a_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        bus3.a_valid = 1'b0;
        n = 0; hi = 0;
        while (!bus3.rsp_valid && n < 20) begin
            if (bus3.alu_instruction == 5'd8) hi++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 4) begin errors++; $display("FAIL lat3_latency got %0d want 4", n); end
        checks++;
        if (hi !== 4) begin errors++; $display("FAIL lat3_instr_hold got %0d want 4", hi); end
        checks++;
        if (rsp3 !== {1'b1, 1'b0, 32'd0, 4'b0110, 1'b0}) begin
            errors++; $display("FAIL lat3_rsp got %h want %h", rsp3, {1'b1, 1'b0, 32'd0, 4'b0110, 1'b0});
        end
        @(negedge clk);
        checks++;
        if (bus3.rsp_valid !== 1'b0) begin errors++; $display("FAIL lat3_rsp_clear got %b want 0", bus3.rsp_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_illegal();
        test_opc_bounds();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_latency3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_scheduler.md
Name: alu_scheduler

Overview:
- Two-port round-robin arbiter and sequencer in front of the shared 32-bit ALU.
- Accepts one operation at a time from requester A or B over a valid/ready handshake.
- Drives the ALU instruction and operand inputs, then holds them until the ALU's registered result is valid.
- Captures the result and flags and returns them on a single response channel tagged with the requester ID.

Parameters:
- ALU_LATENCY, 1: clock edges between the edge that presents the instruction and the edge at which the ALU result/flags become valid. Range 1..7.
- OPC_MAX, 18: highest legal opcode. Legal set is 1..OPC_MAX.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  requester A has an operation
- a_ready  out  1  requester A operation accepted this cycle
- a_instr  in  5  requester A opcode
- a_op1  in  32  requester A operand 1
- a_op2  in  32  requester A operand 2
- b_valid, b_ready, b_instr, b_op1, b_op2: same as the A port, for requester B
- alu_instruction  out  5  to ALU instruction; 0 (NOP) when idle
- alu_num1  out  32  to ALU num1
- alu_num2  out  32  to ALU num2
- alu_result  in  32  from ALU result
- alu_flags  in  4  from ALU flags {V,C,Z,N}
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  0 = A, 1 = B
- rsp_result  out  32  captured result
- rsp_flags  out  4  captured flags
- rsp_err  out  1  opcode was illegal; operation not issued

Behaviour:
- Reset (async, rst_n low):
  - State IDLE, rr_ptr = 0 (A favoured), wait counter = 0.
  - All outputs 0, including alu_instruction = 0.
  - Any in-flight operation is dropped; the ALU result is ignored.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant logic is combinational. If only one valid is high, that requester wins. If both are high, rr_ptr selects the winner (0 = A, 1 = B).
  - Only the winner's ready is high, and only in IDLE. The other ready is 0.
  - Transfer occurs on valid && ready at the clock edge.
  - Legal opcode (1..OPC_MAX):
    - Register the opcode and operands onto alu_instruction/alu_num1/alu_num2.
    - Load cnt = ALU_LATENCY; go to EXEC.
  - Illegal opcode (0 or > OPC_MAX):
    - Do not drive the ALU.
    - Set rsp_err = 1, rsp_result = 0, rsp_flags = 0; go directly to RESP.
- EXEC:
  - ALU inputs are held constant; the ALU re-evaluates every edge, so the instruction must not drop early.
  - When cnt != 0: decrement.
  - When cnt == 0: capture alu_result and alu_flags into rsp_result/rsp_flags, set rsp_err = 0, set alu_instruction = 0, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_result, rsp_flags and rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: go to IDLE, rr_ptr = ~rsp_id, clear rsp_valid.
  - No new request is accepted in RESP.
- Timing:
  - Accept edge E0 to rsp_valid high: ALU_LATENCY+1 cycles.
  - Maximum throughput is one operation per ALU_LATENCY+3 cycles when rsp_ready is held high.
- Requesters hold valid and their fields stable until ready. Withdrawing valid before ready is a protocol violation; no checking is performed.
- rsp_flags reflects the ALU flag register as captured, including flags left unchanged by non-flag-setting ops (extends).
- Only one operation is outstanding at any time; no buffering.

Optional Feature:
- Macro: ALU_SCHED_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_a_ops[15:0], perf_b_ops[15:0] and perf_busy[15:0].
  - perf_a_ops / perf_b_ops increment on each completed response handshake for that requester.
  - perf_busy increments every cycle the state is not IDLE.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and registers do not exist.

Test Plan:
- Single op: A sends ADDS(6), op1 = 5, op2 = 7; rsp_ready = 1.
  - a_ready pulses once; alu_instruction = 6 for ALU_LATENCY+1 cycles.
  - rsp_valid rises 2 cycles after accept with rsp_id = 0, rsp_result = 12, rsp_flags[1] = 0, rsp_err = 0.
- Contention: a_valid and b_valid both high from reset, A = ANDS(1) 0xF0 & 0x0F, B = EORS(4) 0xFF ^ 0x0F.
  - A served first: result 0, rsp_flags = 4'b0010.
  - Then B: result 0xF0.
  - Third request from A again while B is pending is granted after B.
- Illegal opcode: B sends instr 0x1F.
  - ALU instruction stays 0.
  - rsp_valid rises the cycle after accept with rsp_err = 1, rsp_result = 0, rsp_id = 1.
- Backpressure: rsp_ready = 0 for 10 cycles after rsp_valid.
  - Response fields stay constant; a_ready/b_ready remain 0.
  - Handshake occurs on the first cycle rsp_ready = 1.
- Reset mid-op: assert rst_n = 0 during EXEC of SUB(8) 9 - 4.
  - All outputs 0 immediately (asynchronously); no response is issued after release.
  - The next request completes normally.
- ALU_LATENCY = 3 build: SUB 3 - 3.
  - alu_instruction held 4 cycles; rsp_result = 0, rsp_flags[1] = 1, rsp_valid 4 cycles after accept.
